// File: rtl/msa_pkg.sv
// Shared geometry and index helpers for the multi-head attention head-join block.
package msa_pkg;

    localparam int MSA_DATA_WIDTH       = 8;
    localparam int MSA_NUM_HEADS        = 2;
    localparam int MSA_IN_PARALLELISM   = 3;
    localparam int MSA_HEAD_PARALLELISM = 3;
    localparam int MSA_FIFO_DEPTH       = 4;
    localparam int MSA_FRAME_BEATS      = 6;

    localparam int BEAT_ELEMS = MSA_IN_PARALLELISM * MSA_HEAD_PARALLELISM;
    localparam int CNT_WIDTH  = (MSA_FRAME_BEATS > 1) ? $clog2(MSA_FRAME_BEATS) : 1;

    // order 0: token-major interleave of heads; order 1: head-major passthrough
    function automatic int out_index(input int i, input int j, input int k, input int order,
                                     input int nh = MSA_NUM_HEADS,
                                     input int ip = MSA_IN_PARALLELISM,
                                     input int hp = MSA_HEAD_PARALLELISM);
        if (order == 0)
            return (i * nh + j) * hp + k;
        return (j * ip + i) * hp + k;
    endfunction

    function automatic int in_index(input int i, input int j, input int k,
                                    input int ip = MSA_IN_PARALLELISM,
                                    input int hp = MSA_HEAD_PARALLELISM);
        return (j * ip + i) * hp + k;
    endfunction

endpackage

// File: rtl/msa_beat_fifo.sv
// Per-head beat buffer: registered storage, no read/write pass-through.
module msa_beat_fifo
    import msa_pkg::*;
#(
    parameter int DATA_WIDTH = MSA_DATA_WIDTH,
    parameter int ELEMS      = BEAT_ELEMS,
    parameter int DEPTH      = MSA_FIFO_DEPTH
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             push_i,
    input  logic [ELEMS-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic                             pop_i,
    output logic [ELEMS-1:0][DATA_WIDTH-1:0] rdata_o,
    output logic                             full_o,
    output logic                             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DEPTH-1:0][ELEMS-1:0][DATA_WIDTH-1:0] mem_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;

    // Extra pointer MSB separates full from empty when the address bits match.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + PW'(do_push);
    assign rd_ptr_d = rd_ptr_q + PW'(do_pop);
    assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fixed_msa_head_join.sv
// Joins per-head attention beats into one concatenated stream, with head masking
// and frame tracking; a beat leaves only when every enabled head has one queued.
module fixed_msa_head_join
    import msa_pkg::*;
#(
    parameter int DATA_WIDTH       = MSA_DATA_WIDTH,
    parameter int NUM_HEADS        = MSA_NUM_HEADS,
    parameter int IN_PARALLELISM   = MSA_IN_PARALLELISM,
    parameter int HEAD_PARALLELISM = MSA_HEAD_PARALLELISM,
    parameter int FIFO_DEPTH       = MSA_FIFO_DEPTH,
    parameter int FRAME_BEATS      = MSA_FRAME_BEATS,
    parameter int OUT_ORDER        = 0
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic [NUM_HEADS*IN_PARALLELISM*HEAD_PARALLELISM-1:0][DATA_WIDTH-1:0] head_data_in,
    input  logic [NUM_HEADS-1:0]                                         head_data_in_valid,
    output logic [NUM_HEADS-1:0]                                         head_data_in_ready,
    input  logic [NUM_HEADS-1:0]                                         head_mask,
    output logic [NUM_HEADS-1:0]                                         active_mask,
    output logic [IN_PARALLELISM*NUM_HEADS*HEAD_PARALLELISM-1:0][DATA_WIDTH-1:0] data_out,
    output logic                                                         data_out_valid,
    input  logic                                                         data_out_ready,
    output logic                                                         data_out_last
);

    localparam int BEAT_N = IN_PARALLELISM * HEAD_PARALLELISM;
    localparam int CNT_W  = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BEATS - 1);

    logic [NUM_HEADS-1:0]                   full, empty, push, pop;
    logic [NUM_HEADS-1:0]                   active_q, active_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d;
    logic [BEAT_N-1:0][DATA_WIDTH-1:0]      rd_beat [NUM_HEADS];
    logic                                   fire, mask_upd;

    // The mask may only switch on a frame boundary with nothing buffered, so no
    // head can be stranded with data after it is disabled.
    assign mask_upd = (cnt_q == '0) && (&empty);
    assign active_d = mask_upd ? head_mask : active_q;

    assign head_data_in_ready = {NUM_HEADS{rst}} & (~active_d | ~full);
    assign push               = active_d & head_data_in_valid & head_data_in_ready;

    assign data_out_valid = (|active_q) && (&(~active_q | ~empty));
    assign fire           = data_out_valid && data_out_ready;
    assign pop            = {NUM_HEADS{fire}} & active_q;
    assign data_out_last  = data_out_valid && (cnt_q == LAST_CNT);
    assign active_mask    = active_q;

    always_comb begin
        cnt_d = cnt_q;
        if (fire)
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            active_q <= '1;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    for (genvar gj = 0; gj < NUM_HEADS; gj++) begin : g_fifo
        msa_beat_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .ELEMS      (BEAT_N),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk),
            .rst_ni  (rst),
            .push_i  (push[gj]),
            .wdata_i (head_data_in[in_index(0, gj, 0, IN_PARALLELISM, HEAD_PARALLELISM) +: BEAT_N]),
            .pop_i   (pop[gj]),
            .rdata_o (rd_beat[gj]),
            .full_o  (full[gj]),
            .empty_o (empty[gj])
        );
    end

    for (genvar gj = 0; gj < NUM_HEADS; gj++) begin : g_head
        for (genvar gi = 0; gi < IN_PARALLELISM; gi++) begin : g_tok
            for (genvar gk = 0; gk < HEAD_PARALLELISM; gk++) begin : g_elem
                localparam int OI = out_index(gi, gj, gk, OUT_ORDER,
                                              NUM_HEADS, IN_PARALLELISM, HEAD_PARALLELISM);
                assign data_out[OI] = (data_out_valid && active_q[gj])
                                      ? rd_beat[gj][gi*HEAD_PARALLELISM+gk] : '0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_msa_head_join.sv
// Directed bench for fixed_msa_head_join: token-major and head-major builds driven side by side.
module tb_fixed_msa_head_join;

    localparam int DW = 8;
    localparam int NH = 2;
    localparam int IP = 3;
    localparam int HP = 3;
    localparam int TN = NH * IP * HP;
    localparam int FB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [TN-1:0][DW-1:0]  hdata;
    logic [NH-1:0]          hvalid, hmask;
    logic [NH-1:0]          hready0, hready1, amask0, amask1;
    logic [TN-1:0][DW-1:0]  dout0, dout1;
    logic                   v0, v1, l0, l1, oready;

    fixed_msa_head_join #(.OUT_ORDER(0)) u_dut0 (
        .clk(clk), .rst(rst), .head_data_in(hdata), .head_data_in_valid(hvalid),
        .head_data_in_ready(hready0), .head_mask(hmask), .active_mask(amask0),
        .data_out(dout0), .data_out_valid(v0), .data_out_ready(oready), .data_out_last(l0)
    );

    fixed_msa_head_join #(.OUT_ORDER(1)) u_dut1 (
        .clk(clk), .rst(rst), .head_data_in(hdata), .head_data_in_valid(hvalid),
        .head_data_in_ready(hready1), .head_mask(hmask), .active_mask(amask1),
        .data_out(dout1), .data_out_valid(v1), .data_out_ready(oready), .data_out_last(l1)
    );

    int ntest = 0;
    int nfail = 0;

    int hb [NH];
    int hn [NH];
    int hs [NH];
    int pc [NH];
    int ob, cyc, first_v, msw, bp_lo, bp_hi;
    logic [NH-1:0]         emask_a, emask_b;
    logic                  held_v;
    logic [TN-1:0][DW-1:0] held;

    for (genvar gj = 0; gj < NH; gj++) begin : g_mon
        int bad = 0;
        always @(posedge clk) begin
            if ((u_dut0.g_fifo[gj].u_fifo.push_i && u_dut0.g_fifo[gj].u_fifo.full_o) ||
                (u_dut0.g_fifo[gj].u_fifo.pop_i  && u_dut0.g_fifo[gj].u_fifo.empty_o) ||
                (u_dut1.g_fifo[gj].u_fifo.push_i && u_dut1.g_fifo[gj].u_fifo.full_o) ||
                (u_dut1.g_fifo[gj].u_fifo.pop_i  && u_dut1.g_fifo[gj].u_fifo.empty_o))
                bad <= bad + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [287:0] act, input logic [287:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int h, input int b, input int i, input int k);
        return DW'(b * 32 + h * 16 + i * 4 + k);
    endfunction

    task automatic clr();
        for (int j = 0; j < NH; j++) begin
            hb[j] = 0; hn[j] = 0; hs[j] = 0; pc[j] = 0;
        end
        ob = 0; cyc = 0; first_v = -1; msw = 1000;
        bp_lo = -1; bp_hi = -1;
        emask_a = '1; emask_b = '1;
        held_v = 1'b0; held = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0; hvalid = '0; oready = 1'b1; hmask = '1;
        @(negedge clk); #1;
        check_eq("rst_vld",   {v0, v1}, 2'b00);
        check_eq("rst_rdy",   {hready0, hready1}, 4'h0);
        check_eq("rst_last",  {l0, l1}, 2'b00);
        check_eq("rst_amask", {amask0, amask1}, 4'hf);
        check_eq("rst_dout",  {dout0, dout1}, '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive at the falling edge, sample just after, update bookkeeping on the rising edge.
    task automatic step();
        logic [NH-1:0]         fin, em;
        logic                  fout;
        logic [TN-1:0][DW-1:0] e0, e1;
        logic [DW-1:0]         val;
        for (int j = 0; j < NH; j++) begin
            hvalid[j] = (cyc >= hs[j]) && (hb[j] < hn[j]);
            for (int i = 0; i < IP; i++)
                for (int k = 0; k < HP; k++)
                    hdata[(j*IP+i)*HP+k] = pat(j, hb[j], i, k);
        end
        oready = !(cyc >= bp_lo && cyc < bp_hi);
        #1;
        fin  = hvalid & hready0;
        fout = v0 && oready;
        em   = (ob >= msw) ? emask_b : emask_a;
        if (v0 && first_v < 0) first_v = cyc;
        if (held_v) begin
            check_eq("hold_dout", dout0, held);
            check_eq("hold_vld", v0, 1'b1);
        end
        if (fout) begin
            e0 = '0;
            e1 = '0;
            for (int j = 0; j < NH; j++)
                for (int i = 0; i < IP; i++)
                    for (int k = 0; k < HP; k++) begin
                        val = em[j] ? pat(j, pc[j], i, k) : '0;
                        e0[(i*NH+j)*HP+k] = val;
                        e1[(j*IP+i)*HP+k] = val;
                    end
            check_eq("beat_order0", dout0, e0);
            check_eq("beat_order1", dout1, e1);
            check_eq("vld_order1", v1, 1'b1);
            check_eq("last", {l0, l1}, (ob % FB == FB - 1) ? 2'b11 : 2'b00);
        end
        held_v = v0 && !oready;
        held   = dout0;
        @(posedge clk);
        for (int j = 0; j < NH; j++) begin
            if (fin[j]) hb[j]++;
            if (fout && em[j]) pc[j]++;
        end
        if (fout) ob++;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit midck;
        rst = 1'b0; hvalid = '0; hdata = '0; hmask = '1; oready = 1'b1;

        // aligned heads, two frames back to back
        clr(); do_reset();
        hn[0] = 12; hn[1] = 12;
        step();
        check_eq("p1_dout3_order0", dout0[3], 8'd16);
        check_eq("p1_dout3_order1", dout1[3], 8'd4);
        while (ob < 12 && cyc < 60) step();
        check_eq("p1_first_valid", first_v, 1);
        check_eq("p1_beats", ob, 12);
        check_eq("p1_cycles", cyc, 13);

        // head 1 lags head 0 by three beats
        clr(); do_reset();
        hn[0] = 6; hn[1] = 6; hs[1] = 3;
        for (int n = 0; n < 4; n++) step();
        check_eq("p2_h0_full_rdy", hready0[0], 1'b0);
        check_eq("p2_vld_after_h1", v0, 1'b1);
        step();
        check_eq("p2_h0_rdy_back", hready0[0], 1'b1);
        while (ob < 6 && cyc < 60) step();
        check_eq("p2_first_valid", first_v, 4);
        check_eq("p2_beats", ob, 6);

        // five cycles of output backpressure mid-frame
        clr(); do_reset();
        hn[0] = 6; hn[1] = 6; bp_lo = 2; bp_hi = 7;
        for (int n = 0; n < 5; n++) step();
        check_eq("p3_both_full", hready0, 2'b00);
        while (ob < 6 && cyc < 60) step();
        check_eq("p3_beats", ob, 6);
        check_eq("p3_sent", {hb[0], hb[1]}, {32'd6, 32'd6});

        // head 1 pruned mid-frame; takes effect on the next frame
        clr(); do_reset();
        hn[0] = 6; hn[1] = 6; msw = 6; emask_b = 2'b01;
        midck = 1'b0;
        while (ob < 6 && cyc < 60) begin
            step();
            if (ob >= 2) hmask = 2'b01;
            if (ob == 4 && !midck) begin
                check_eq("p4_amask_mid", {amask0, amask1}, 4'hf);
                midck = 1'b1;
            end
        end
        check_eq("p4_amask_frame_end", {amask0, amask1}, 4'hf);
        step();
        check_eq("p4_amask_new", {amask0, amask1}, 4'b0101);
        hn[0] = 12; hn[1] = 12;
        step();
        check_eq("p4_h1_rdy", {hready0[1], hready1[1]}, 2'b11);
        while (ob < 12 && cyc < 80) step();
        check_eq("p4_beats", ob, 12);
        hmask = '1;

        // reset pulse after the third beat
        clr(); do_reset();
        hn[0] = 12; hn[1] = 12;
        while (ob < 3 && cyc < 60) step();
        rst = 1'b0;
        #1;
        check_eq("p6_vld_drop", {v0, v1}, 2'b00);
        check_eq("p6_rdy_drop", {hready0, hready1}, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("p6_empty", v0, 1'b0);
        clr();
        hn[0] = 6; hn[1] = 6;
        while (ob < 6 && cyc < 60) step();
        check_eq("p6_beats", ob, 6);

        check_eq("ovf_udf", g_mon[0].bad + g_mon[1].bad, 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/fixed_msa_head_join.md
Name: fixed_msa_head_join

Overview:
- Joins the per-head self-attention outputs of a multi-head attention block into one concatenated stream for the output projection.
- Each head gets its own buffer, so heads may finish at different times. A beat is emitted only when every enabled head has data.
- Adds a runtime head mask for head pruning, a selectable output ordering, and frame tracking with a last-beat flag.

Parameters:
DATA_WIDTH, 8, element width in bits
NUM_HEADS, 2, number of head input channels
IN_PARALLELISM, 3, tokens (rows) per beat
HEAD_PARALLELISM, 3, elements per token per head per beat
FIFO_DEPTH, 4, per-head buffer depth in beats; power of 2, >=2
FRAME_BEATS, 6, output beats per frame (IN_NUM_PARALLELISM*head-dim depth)
OUT_ORDER, 0, 0 = token-major interleave, 1 = head-major passthrough

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
head_data_in  in  DATA_WIDTH x [NUM_HEADS*IN_PARALLELISM*HEAD_PARALLELISM]  element (j*IN_PARALLELISM+i)*HEAD_PARALLELISM+k = head j, token i, elem k
head_data_in_valid  in  NUM_HEADS  per-head valid
head_data_in_ready  out  NUM_HEADS  per-head ready
head_mask  in  NUM_HEADS  requested head enables (1 = enabled)
active_mask  out  NUM_HEADS  enables currently in force
data_out  out  DATA_WIDTH x [IN_PARALLELISM*NUM_HEADS*HEAD_PARALLELISM]  concatenated beat
data_out_valid  out  1  output valid
data_out_ready  in  1  output ready
data_out_last  out  1  high on the final beat of each frame

Behaviour:
- Reset while rst=0, at any time including mid-frame:
  - FIFOs empty, active_mask all ones, beat counter 0.
  - data_out_valid=0, data_out_last=0, head_data_in_ready all 0 while asserted.
  - data_out reads as 0.
- Ready:
  - Enabled head j: head_data_in_ready[j] = !full[j].
  - Registered FIFO, so no pass-through: a full FIFO does not accept even while popping that cycle.
  - Disabled head: ready=1; accepted data is discarded and never pushed.
- Push: a valid&&ready beat on enabled head j is written to FIFO j at the clock edge.
- Output valid: data_out_valid = AND over enabled heads of !empty[j]. If active_mask is all zero, valid=0.
- Latency: a beat accepted in cycle N can appear at the output in cycle N+1 at the earliest.
- Pop: on data_out_valid&&data_out_ready, every enabled FIFO pops together.
- Throughput: with FIFO_DEPTH>=2 and no backpressure, one beat per cycle.
- Stability: data_out and data_out_valid hold stable while valid=1 and ready=0.
- Output layout, for head j, token i, element k:
  - OUT_ORDER=0: data_out[(i*NUM_HEADS+j)*HEAD_PARALLELISM+k].
  - OUT_ORDER=1: data_out[(j*IN_PARALLELISM+i)*HEAD_PARALLELISM+k].
  - Disabled-head slices output 0.
- Frame counter:
  - Counts output handshakes from 0 to FRAME_BEATS-1.
  - data_out_last = data_out_valid && (count==FRAME_BEATS-1).
  - On the handshake at FRAME_BEATS-1 the counter wraps to 0.
- Mask update:
  - active_mask <= head_mask only in a cycle where the counter is 0 and all FIFOs are empty.
  - Otherwise the change is held off until that condition holds; no mid-frame change.
- Simultaneous push and pop on the same FIFO when not full: occupancy is unchanged and order is preserved.
- Overflow and underflow cannot occur by construction. The bench asserts this.

Decomposition:
- Package msa_pkg:
  - Function out_index(i,j,k,order) returning the flat output index.
  - Function in_index(i,j,k) returning the flat input index.
  - Localparams BEAT_ELEMS = IN_PARALLELISM*HEAD_PARALLELISM and CNT_WIDTH = $clog2(FRAME_BEATS).
- One sub-module, msa_beat_fifo:
  - Synchronous FIFO of BEAT_ELEMS x DATA_WIDTH words with full/empty, push/pop and async active-low reset.
  - Instantiated NUM_HEADS times in a generate loop.
- The top level holds the valid-join logic, the frame counter and the mask register.

Test Plan:
- Aligned heads: both heads drive beats in the same cycles with data = head*16+token*4+elem, ready=1.
  - Output: one beat per cycle from cycle 1.
  - OUT_ORDER=0: data_out[3] = head 1, token 0, elem 0 = 16.
  - data_out_last on beats 6 and 12.
- Skewed heads: head 1 lags head 0 by 3 beats.
  - First valid is one cycle after head 1's first beat.
  - Head 0 holds 3 beats; it fills at 4 and head_data_in_ready[0] drops until pops begin.
- Backpressure: data_out_ready=0 for 5 cycles mid-frame.
  - data_out stays stable and both FIFOs fill to 4.
  - Resumes with no loss; beat count totals 6.
- Mask change mid-frame: head_mask=2'b01 asserted at beat 2.
  - active_mask changes only after beat 6 drains.
  - Next frame: head 1 slices are 0, head 1 ready stays 1, and valid depends only on head 0.
- OUT_ORDER=1 build: the same stimulus gives data_out identical to the head-major input concatenation.
- Reset mid-frame: rst=0 for 1 cycle after beat 3.
  - Valid drops immediately and FIFOs are emptied.
  - The next frame's last flag falls on its 6th beat.
